freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Gated edge counter that measures the frequency of an asynchronous input signal.
- Counts rising edges over a fixed window of GATE_CYCLES clk cycles, then publishes the count as a stable 32-bit value.
- Output freq_count drives the in_port of a 32-bit read-only Avalon PIO, so software reads Hz directly when the gate is 1 s.
- Sits directly upstream of that PIO in the Computer_System top level.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); legal range 2 to 2^32-1.
- COUNT_W, 32, width of edge counter and freq_count; must not exceed the PIO width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  synchronous run control; 1 = measure continuously.
- sig_in  input  1  asynchronous signal under measurement.
- freq_count  output  COUNT_W  rising-edge count of the last completed window.
- update  output  1  one-cycle strobe; freq_count changed this cycle.
- overflow  output  1  last completed window saturated the counter.
- busy  output  1  1 while in MEASURE.

Behaviour:
- Reset: the block clears all registers asynchronously, including freq_count=0, update=0, overflow=0 and busy=0. State goes to IDLE, and the synchronizer flops and gate/edge counters go to 0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then a third flop for edge detection.
  - edge = sync2 & ~sync3.
  - A rising edge on sig_in is counted 2-3 clk cycles after it occurs.
  - Minimum countable period is 2 clk cycles; faster inputs alias and this is not flagged.
- State machine:
  - IDLE: busy=0, gate_cnt=0, edge_cnt=0. When enable=1, go to MEASURE on the next cycle.
  - MEASURE: busy=1.
    - gate_cnt increments every cycle.
    - edge_cnt increments on each edge, saturating at all-ones. A saturating increment sets the internal sat flag.
  - Window close, when gate_cnt==GATE_CYCLES-1 and enable=1:
    - freq_count <= edge_cnt + edge, saturated: an edge in the closing cycle belongs to the closing window.
    - overflow <= sat, or the closing increment saturates.
    - update=1 for exactly that one cycle.
    - gate_cnt, edge_cnt and sat are cleared, and the next window starts on the following cycle with no dead time. The state stays MEASURE.
  - enable=0 while in MEASURE (including the closing cycle):
    - Abort: return to IDLE and clear the partial counts.
    - freq_count and overflow hold their last published values; no update pulse.
- Output stability: freq_count changes only in update cycles, so any PIO sample taken between updates is coherent.
- First result appears GATE_CYCLES+1 cycles after enable rises (1 cycle IDLE→MEASURE, plus the window).
- Reset mid-window: everything clears immediately; there is no partial publish.
- Arithmetic: unsigned throughout; no wrap-around of edge_cnt, saturation only.

Test Plan (bench uses GATE_CYCLES=100, COUNT_W=8 unless stated):
- Reset/idle: hold reset_n=0, then release with enable=0 for 500 cycles, sig_in toggling -> freq_count=0, update never asserted, busy=0.
- Basic count: enable=1, sig_in square wave period 10 clk -> update every 100 cycles, first at cycle 101 after enable. freq_count=10 (±1 on the first window only, for phase), then exactly 10 on later windows.
- Boundary edge: place a sig_in rising edge so the synchronized edge lands on gate_cnt==99 -> it is counted in the closing window (e.g. 5 edges placed, the 5th in the last cycle -> freq_count=5); the next window starts from 0.
- Saturation: COUNT_W=4, period-2 square wave (50 edges/window) -> freq_count=15, overflow=1. Then switch to period 20 -> next window freq_count=5, overflow=0.
- Abort: enable=1 for 60 cycles, then 0, with a prior published freq_count=10 -> freq_count stays 10, no update, busy=0. Re-enable -> a fresh full 100-cycle window is measured.
- Async reset mid-window: assert reset_n=0 at gate_cnt=50 -> freq_count=0 and busy=0 immediately (no clk edge required). After release with enable=1 -> first update 101 cycles later.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter for an asynchronous input.
// Counts synchronized rising edges of sig_in over GATE_CYCLES clk cycles and
// publishes the saturated count in freq_count. The published value changes
// only in the cycle flagged by update, so a reader polling between updates
// always sees a coherent value.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               update,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [31:0] LP_GATE_LAST = 32'(GATE_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_busy;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic                 w_edge;

  logic [31:0]          r_gate_cnt;
  logic [COUNT_W-1:0]   r_edge_cnt;
  logic                 r_sat;

  logic [COUNT_W-1:0]   r_freq_count;
  logic                 r_update;
  logic                 r_overflow;

  logic                 w_cnt_full;
  logic                 w_inc_sat;
  logic [COUNT_W-1:0]   w_edge_inc;
  logic                 w_run;
  logic                 w_close;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= sig_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Edge detect, saturating increment and window-close decode.
  always_comb begin
    w_edge     = r_sync2 & ~r_sync3;
    w_cnt_full = &r_edge_cnt;
    w_inc_sat  = w_edge & w_cnt_full;
    w_edge_inc = r_edge_cnt;
    if (w_edge && !w_cnt_full) begin
      w_edge_inc = r_edge_cnt + COUNT_W'(1);
    end
    w_run   = (r_state == MEASURE) && enable;
    w_close = w_run && (r_gate_cnt == LP_GATE_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and busy decode.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = MEASURE;
        end
      end
      MEASURE: begin
        w_busy = 1'b1;
        if (!enable) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Gate/edge counters and the published result. The closing cycle folds in
  // its own edge, so the next window starts clean with no dead cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_sat        <= 1'b0;
      r_freq_count <= '0;
      r_update     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (w_close) begin
        r_freq_count <= w_edge_inc;
        r_overflow   <= r_sat | w_inc_sat;
        r_update     <= 1'b1;
        r_gate_cnt   <= '0;
        r_edge_cnt   <= '0;
        r_sat        <= 1'b0;
      end else if (w_run) begin
        r_gate_cnt <= r_gate_cnt + 32'd1;
        r_edge_cnt <= w_edge_inc;
        if (w_inc_sat) begin
          r_sat <= 1'b1;
        end
      end else begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end
    end
  end

  assign freq_count = r_freq_count;
  assign update     = r_update;
  assign overflow   = r_overflow;
  assign busy       = w_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: two instances (8-bit and 4-bit counters, 100-cycle
// gate) share stimulus and are compared every cycle against a window-level
// reference model, plus table-driven end-of-phase checks and corner sequences.
module tb_freq_meter;

  localparam int GATE = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       sig_in;
  logic [7:0] f8;
  logic [3:0] f4;
  logic       u8, u4, o8, o4, b8, b4;

  int checks = 0;
  int errors = 0;

  // Reference model state: sampled-input history and window bookkeeping.
  bit smp[3];
  bit m_meas;
  int m_elapsed;
  int m_count;
  int m_pub;
  bit m_upd;

  // Square-wave generator state; period 0 means random per-cycle level.
  int period;
  int ph;

  typedef struct {
    int en;      // 0, 1, or 2 = random toggling
    int period;
    int cycles;
    int f8;      // -1 = not checked
    int o8;
    int f4;
    int o4;
  } vec_t;

  vec_t tbl[7];

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_count(f8), .update(u8), .overflow(o8), .busy(b8)
  );

  freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_count(f4), .update(u4), .overflow(o4), .busy(b4)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int satw(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) smp[i] = 1'b0;
    m_meas    = 1'b0;
    m_elapsed = 0;
    m_count   = 0;
    m_pub     = 0;
    m_upd     = 1'b0;
  endtask

  // One clock edge of the reference: a rising level seen at sample n is
  // credited to the window at edge n+2; windows are GATE edges long.
  task automatic model_step();
    int e;
    int total;
    if (!reset_n) begin
      model_reset();
      return;
    end
    e = (smp[1] && !smp[2]) ? 1 : 0;
    smp[2] = smp[1];
    smp[1] = smp[0];
    smp[0] = sig_in;
    m_upd  = 1'b0;
    if (!m_meas) begin
      if (enable) begin
        m_meas    = 1'b1;
        m_elapsed = 0;
        m_count   = 0;
      end
    end else if (!enable) begin
      m_meas = 1'b0;
    end else begin
      total = m_count + e;
      if (m_elapsed == GATE - 1) begin
        m_pub     = total;
        m_upd     = 1'b1;
        m_count   = 0;
        m_elapsed = 0;
      end else begin
        m_count = total;
        m_elapsed++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("f8",   int'(f8), satw(m_pub, 8));
    chk("o8",   int'(o8), (m_pub > 255) ? 1 : 0);
    chk("f4",   int'(f4), satw(m_pub, 4));
    chk("o4",   int'(o4), (m_pub > 15) ? 1 : 0);
    chk("upd8", int'(u8), int'(m_upd));
    chk("upd4", int'(u4), int'(m_upd));
    chk("bsy8", int'(b8), int'(m_meas));
    chk("bsy4", int'(b4), int'(m_meas));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_sig();
    if (period == 0) sig_in = 1'($urandom % 2);
    else             sig_in = ((ph % period) < (period / 2));
    ph++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear with no clock.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_f8",  int'(f8), 0);
    chk("rst_f4",  int'(f4), 0);
    chk("rst_o4",  int'(o4), 0);
    chk("rst_u8",  int'(u8), 0);
    chk("rst_b8",  int'(b8), 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_sig();
      tick();
    end
    reset_n = 1'b1;
  endtask

  task automatic wait_update(output int n);
    n = 0;
    while (n < 300) begin
      drive_sig();
      tick();
      n++;
      if (u8) break;
    end
  endtask

  initial begin
    int n;
    int seen;

    tbl[0] = '{en: 0, period: 10, cycles: 500, f8: 0,  o8: 0,  f4: 0,  o4: 0};
    tbl[1] = '{en: 1, period: 10, cycles: 350, f8: 10, o8: 0,  f4: 10, o4: 0};
    tbl[2] = '{en: 1, period: 2,  cycles: 350, f8: 50, o8: 0,  f4: 15, o4: 1};
    tbl[3] = '{en: 1, period: 20, cycles: 350, f8: 5,  o8: 0,  f4: 5,  o4: 0};
    tbl[4] = '{en: 1, period: 4,  cycles: 350, f8: 25, o8: 0,  f4: 15, o4: 1};
    tbl[5] = '{en: 1, period: 0,  cycles: 400, f8: -1, o8: -1, f4: -1, o4: -1};
    tbl[6] = '{en: 2, period: 0,  cycles: 800, f8: -1, o8: -1, f4: -1, o4: -1};

    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    period  = 10;
    ph      = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      drive_sig();
      tick();
    end
    reset_n = 1'b1;

    // Table-driven phases: idle, steady periods, saturation, random.
    for (int t = 0; t < 7; t++) begin
      period = tbl[t].period;
      ph     = 0;
      if (tbl[t].en < 2) enable = (tbl[t].en == 1);
      for (int c = 0; c < tbl[t].cycles; c++) begin
        if (tbl[t].en == 2 && $urandom_range(0, 63) == 0) enable = ~enable;
        drive_sig();
        tick();
      end
      if (tbl[t].f8 >= 0) begin
        chk($sformatf("tbl%0d_f8", t), int'(f8), tbl[t].f8);
        chk($sformatf("tbl%0d_o8", t), int'(o8), tbl[t].o8);
        chk($sformatf("tbl%0d_f4", t), int'(f4), tbl[t].f4);
        chk($sformatf("tbl%0d_o4", t), int'(o4), tbl[t].o4);
      end
    end

    // First result latency after enable rises from reset.
    enable = 1'b0;
    period = 10;
    do_reset();
    ph     = 0;
    enable = 1'b1;
    wait_update(n);
    chk("lat_first", n, GATE + 1);

    // Edge landing in the closing cycle belongs to the closing window.
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int m = 1; m <= GATE + 1; m++) begin
      sig_in = (m == 10 || m == 30 || m == 50 || m == 70 || m == GATE - 1);
      tick();
    end
    chk("bnd_upd", int'(u8), 1);
    chk("bnd_f8",  int'(f8), 5);
    chk("bnd_f4",  int'(f4), 5);
    sig_in = 1'b0;
    for (int m = 0; m < GATE; m++) tick();
    chk("bnd_next_upd", int'(u8), 1);
    chk("bnd_next_f8",  int'(f8), 0);

    // Abort mid-window holds the last published value.
    enable = 1'b0;
    period = 10;
    do_reset();
    ph     = 0;
    enable = 1'b1;
    for (int i = 0; i < 2 * GATE + 1; i++) begin
      drive_sig();
      tick();
    end
    chk("abt_pre_f8", int'(f8), 10);
    for (int i = 0; i < 60; i++) begin
      drive_sig();
      tick();
    end
    enable = 1'b0;
    seen   = 0;
    for (int i = 0; i < 50; i++) begin
      drive_sig();
      tick();
      if (u8 || u4) seen++;
    end
    chk("abt_noupd", seen, 0);
    chk("abt_f8",    int'(f8), 10);
    chk("abt_busy",  int'(b8), 0);
    enable = 1'b1;
    wait_update(n);
    chk("abt_relat", n, GATE + 1);
    chk("abt_ref8",  int'(f8), 10);

    // Asynchronous reset in the middle of a window after a publish.
    for (int i = 0; i < 50; i++) begin
      drive_sig();
      tick();
    end
    chk("mid_pre_f8", int'(f8), 10);
    do_reset();
    wait_update(n);
    chk("mid_lat", n, GATE + 1);
    chk("mid_f8",  int'(f8), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
